// File: rtl/mem_access_stage.sv
// Memory-access stage sitting in front of Memory_File. Accepts one load or
// store per handshake, turns byte addresses into word indices, performs
// byte/half stores as read-modify-write and returns extended load data
// through a valid/ready response channel.
module mem_access_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [4:0]        req_rd,
  output logic [31:0]       mem_read_sel,
  output logic [31:0]       mem_write_sel,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [4:0]        rsp_rd,
  output logic              rsp_misalign
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] RSP  = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]        state_q, state_d;
  logic [31:0]       sel_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic [1:0]        lane_q;
  logic [DATA_W-1:0] wdata_q;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              mis_q;

  logic              accept;
  logic              fault;
  logic [31:0]       word_idx;
  logic [7:0]        byte_f;
  logic [15:0]       half_f;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] merged;

  assign accept   = req_valid && (state_q == IDLE);
  assign word_idx = 32'(req_addr[ADDR_W-1:2]);

  // Alignment / size fault detection on the incoming request.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    fault = 1'b0;
    case (req_size)
      SZ_BYTE: fault = 1'b0;
      SZ_HALF: fault = req_addr[0];
      SZ_WORD: fault = (req_addr[1:0] != 2'b00);
      default: fault = 1'b1;
    endcase
  end

  // Next-state logic: faults skip memory; word stores skip the read.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) begin
        if (fault)                          state_d = RSP;
        else if (req_we && req_size == SZ_WORD) state_d = WR;
        else                                state_d = RD;
      end
      RD:      state_d = we_q ? WR : RSP;
      WR:      state_d = RSP;
      default: if (rsp_ready) state_d = IDLE;
    endcase
  end

  // Load-data extraction and extension from the word presented in RD.
  always_comb begin
    byte_f   = mem_rdata[8*lane_q +: 8];
    half_f   = mem_rdata[16*lane_q[1] +: 16];
    load_ext = mem_rdata;
    case (size_q)
      SZ_BYTE: load_ext = {{(DATA_W-8){sgn_q & byte_f[7]}}, byte_f};
      SZ_HALF: load_ext = {{(DATA_W-16){sgn_q & half_f[15]}}, half_f};
      default: load_ext = mem_rdata;
    endcase
  end

  // Store word: lane replacement into the captured word for sub-word stores.
  always_comb begin
    merged = rdata_q;
    case (size_q)
      SZ_BYTE: merged[8*lane_q +: 8]       = wdata_q[7:0];
      SZ_HALF: merged[16*lane_q[1] +: 16]  = wdata_q[15:0];
      default: merged                      = wdata_q;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request capture, read-word capture and response registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: every register here is small control/data state, so all are reset;
    // the memory itself lives in Memory_File and is never touched by reset.
    if (!reset) begin
      sel_q      <= '0;
      we_q       <= 1'b0;
      size_q     <= '0;
      sgn_q      <= 1'b0;
      lane_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      rdata_q    <= '0;
      rsp_data_q <= '0;
      mis_q      <= 1'b0;
    end else begin
      if (accept) begin
        sel_q      <= word_idx;
        we_q       <= req_we;
        size_q     <= req_size;
        sgn_q      <= req_signed;
        lane_q     <= req_addr[1:0];
        wdata_q    <= req_wdata;
        rd_q       <= req_rd;
        mis_q      <= fault;
        rsp_data_q <= '0;
      end
      if (state_q == RD) begin
        if (we_q) rdata_q    <= mem_rdata;
        else      rsp_data_q <= load_ext;
      end
    end
  end

  // mem_we decodes straight from state, so an async reset drops it at once.
  assign mem_we        = (state_q == WR);
  assign mem_wdata     = (state_q == WR) ? merged : '0;
  assign mem_read_sel  = sel_q;
  assign mem_write_sel = sel_q;
  assign req_ready     = (state_q == IDLE);
  assign rsp_valid     = (state_q == RSP);
  assign rsp_data      = rsp_data_q;
  assign rsp_rd        = rd_q;
  assign rsp_misalign  = mis_q;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the Lab3 datapath, directly upstream of `Memory_File`. It accepts one load or store per handshake from the execute stage and converts byte addresses to word indices for `Memory_File`. Byte and halfword stores are performed as read-modify-write. Load data is extracted, extended and returned to writeback through a valid/ready response channel.

## Interface
- `ADDR_W`, 32, byte-address width of requests.
- `DATA_W`, 32, data width; equals the `Memory_File` word width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  stage can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `req_signed`  in  1  sign-extend load result.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  DATA_W  store data, right-aligned.
- `req_rd`  in  5  destination register tag, passed through.
- `mem_read_sel`  out  32  to `Memory_File.ReadSelect1`; word index.
- `mem_write_sel`  out  32  to `Memory_File.WriteSelect`; word index.
- `mem_wdata`  out  DATA_W  to `Memory_File.WriteData`.
- `mem_we`  out  1  to `Memory_File.WriteEnable`.
- `mem_rdata`  in  DATA_W  from `Memory_File.ReadData1`.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  writeback accepts the response.
- `rsp_data`  out  DATA_W  load result; 0 for stores and faults.
- `rsp_rd`  out  5  tag of the completed request.
- `rsp_misalign`  out  1  alignment or size fault; no memory access was made.

## Operation
- **FSM states:** IDLE, RD, WR, RSP.
- **Request capture:** on accept (`req_valid && req_ready`), all `req_*` fields are registered. The word index is `req_addr[ADDR_W-1:2]`, zero-extended to 32 bits. It drives both `mem_read_sel` and `mem_write_sel` and is held until the next accept.
- **Fault check:** a fault is any of: size 11, half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - IDLE→RSP with `rsp_misalign`=1 and `rsp_data`=0.
  - `mem_we` is never asserted for a faulted request.
- **Load:** IDLE→RD→RSP.
  - In RD, `mem_rdata` is valid and is captured at the RD→RSP edge.
  - Byte lane is `addr[1:0]`; byte k occupies bits [8k+7:8k] (little-endian).
  - Half lane is `addr[1]`.
  - The selected field is sign-extended if `req_signed`=1, otherwise zero-extended.
  - A word load returns `mem_rdata` unchanged.
- **Word store:** IDLE→WR→RSP.
  - In WR, `mem_we`=1 and `mem_wdata`=`req_wdata`.
- **Byte/half store:** IDLE→RD→WR→RSP.
  - In RD, the current word is read.
  - In WR, `mem_wdata` is the read word with the addressed lane replaced by `req_wdata[7:0]` (byte) or `req_wdata[15:0]` (half). All other bits are preserved.
- **Response:** in RSP, `rsp_valid`=1 and `rsp_data`, `rsp_rd`, `rsp_misalign` are held stable until `rsp_ready`=1. On `rsp_valid && rsp_ready` the state returns to IDLE. No request is accepted while in RSP.
- **Write pulse:** `mem_we` is high exactly one cycle per store (the WR cycle) and low in every other state.

## Timing
- **Reset values:**
  - State IDLE.
  - `req_ready`=1, `rsp_valid`=0, `mem_we`=0.
  - `mem_read_sel`, `mem_write_sel`, `mem_wdata`, `rsp_data`, `rsp_rd`, `rsp_misalign` all 0.
- **Latency, accept edge to first `rsp_valid` cycle:**
  - Fault: 1 cycle.
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
- **Memory write:** occurs at the rising edge that ends the WR cycle. A subsequent load can read the stored value.
- **Throughput:** at most one request every (latency + 1) cycles, because IDLE must be re-entered before the next accept.
- **Reset mid-operation:** asserting `reset` forces `mem_we` low immediately and asynchronously, so no write occurs unless the WR edge has already passed. The in-flight request is discarded without a response. Memory contents are never altered by reset.
- `req_*` inputs are ignored outside IDLE.
- `mem_rdata` is sampled only at the RD→next edge.

## Test plan
- **Word store then load:** word store addr 0x0C, data 0xDEADBEEF → one-cycle `mem_we` with `mem_write_sel`=3 and `mem_wdata`=0xDEADBEEF. Then word load addr 0x0C → `rsp_data`=0xDEADBEEF, `rsp_valid` 2 cycles after accept.
- **Byte store (read-modify-write):** with word 3 = 0xDEADBEEF, byte store 0xA5 at 0x0D → RD then WR with `mem_wdata`=0xDEADA5EF. Then signed byte load at 0x0D → 0xFFFFFFA5; unsigned → 0x000000A5.
- **Signed half load:** with word 3 = 0xDEADA5EF, signed half load at 0x0E → 0xFFFFDEAD; unsigned → 0x0000DEAD.
- **Misaligned word load:** word load at 0x0E → `rsp_misalign`=1 and `rsp_data`=0 one cycle after accept; `mem_we` stays 0.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles after a load → `rsp_valid`, `rsp_data` and `rsp_rd` stay stable and `req_ready`=0 throughout. Raising `rsp_ready` returns the stage to IDLE, and the next request is accepted one cycle later.
- **Reset during write:** assert `reset` low during the WR cycle of a byte store to 0x0C → `mem_we` drops in the same cycle and word 3 is unchanged. After release: `req_ready`=1, `rsp_valid`=0, and a load of 0x0C returns the old value.
